multisim_client_pull_fifo: RTL

Pull-side multisim client with a prefetch buffer. It fetches words from a named multisim server through the DPI client layer into a FIFO_DEPTH-entry first-word-fall-through FIFO. The FIFO feeds a valid/ready consumer. Empty polls trigger a configurable backoff that throttles DPI traffic. It sits at the client edge of a partitioned simulation and replaces single-register pull clients where the consumer must see back-to-back data.

---
 rtl/multisim_client_pkg.sv | 65 ++++++
 rtl/multisim_client_pull_fifo_fifo.sv | 57 +++++
 rtl/multisim_client_pull_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/multisim_client_pkg.sv
// Shared types, constants and client-layer entry points for the multisim
// pull client and its prefetch FIFO.
package multisim_client_pkg;

  localparam int unsigned DPI_VALID_BIT  = 0;
  localparam int unsigned MAX_DATA_WIDTH = 256;

  typedef logic [MAX_DATA_WIDTH-1:0] dpi_word_t;

  typedef struct packed {
    logic      ok;
    dpi_word_t word;
  } fetch_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned clog2p1(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // In-process loopback client layer with the same call signatures as the C
  // shim: a word queue plays the server, and call counters expose traffic.
  dpi_word_t   srv_q[$];
  int unsigned start_calls = 0;
  int unsigned get_calls   = 0;
  string       last_dir    = "";
  string       last_server = "";

  function automatic void multisim_client_start(input string dir, input string server_name);
    start_calls++;
    last_dir    = dir;
    last_server = server_name;
  endfunction

  function automatic int multisim_client_get_data_packed(input string server_name,
                                                         output dpi_word_t word,
                                                         input int width);
    int        status;
    dpi_word_t mask;
    get_calls++;
    last_server = server_name;
    status      = 0;
    word        = '0;
    if (srv_q.size() != 0) begin
      word   = srv_q.pop_front();
      status = 1;
    end
    mask = (width >= int'(MAX_DATA_WIDTH)) ? '1
         : ((dpi_word_t'(1) << width) - dpi_word_t'(1));
    word = word & mask;
    return status;
  endfunction

  // One poll of the server, folded into a value so it can be registered
  // with a single non-blocking assignment.
  function automatic fetch_t client_fetch(input string server_name, input int width);
    fetch_t    f;
    dpi_word_t w;
    int        status;
    status = multisim_client_get_data_packed(server_name, w, width);
    f.ok   = ((status >> DPI_VALID_BIT) & 1) != 0;
    f.word = w;
    return f;
  endfunction

endpackage

// File: rtl/multisim_client_pull_fifo_fifo.sv
// Small first-word-fall-through FIFO: head always shows the oldest entry.
module multisim_fifo_fwft
  import multisim_client_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [clog2p1(DEPTH)-1:0]   count,
  output logic [WIDTH-1:0]            head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = clog2p1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow; full and empty come from cnt only.
  always_comb begin
    do_push = push && (cnt != CW'(DEPTH));
    do_pop  = pop && (cnt != '0);
    count   = cnt;
    head    = mem[rd_ptr];
  end

  // Storage needs no reset: entries are only visible while cnt covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at a power-of-two depth; cnt tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/multisim_client_pull_fifo.sv
// Pull-side multisim client: polls a server into a prefetch FIFO that feeds
// a valid/ready consumer, with a backoff after empty polls.
module multisim_client_pull_fifo
  import multisim_client_pkg::*;
#(
  parameter string       SERVER_RUNTIME_DIRECTORY = "../output_top",
  parameter int unsigned DATA_WIDTH               = 64,
  parameter int unsigned FIFO_DEPTH               = 4,
  parameter int unsigned POLL_BACKOFF             = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  string                               server_name,
  input  logic                                data_rdy,
  output logic                                data_vld,
  output logic [DATA_WIDTH-1:0]               data,
  output logic [clog2p1(FIFO_DEPTH)-1:0]      fill_level,
  output logic                                poll_idle
);

  localparam int unsigned CW = clog2p1(FIFO_DEPTH);
  localparam int unsigned BW = (POLL_BACKOFF > 0) ? $clog2(POLL_BACKOFF + 1) : 1;

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] word;
    logic [BW-1:0]         backoff;
  } poll_t;

  logic                  stg_vld;
  logic [DATA_WIDTH-1:0] stg_word;
  logic [BW-1:0]         backoff_cnt;
  logic [CW-1:0]         f_count;
  logic [DATA_WIDTH-1:0] f_head;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  pop_stage;
  logic                  pop_fifo;
  logic                  push_fifo;
  logic                  fetch;

  function automatic poll_t poll_server(input string name);
    fetch_t f;
    poll_t  p;
    f         = client_fetch(name, int'(DATA_WIDTH));
    p.vld     = f.ok;
    p.word    = DATA_WIDTH'(f.word);
    p.backoff = f.ok ? '0 : BW'(POLL_BACKOFF);
    return p;
  endfunction

  // Open the client session once at elaboration; reset does not repeat it.
  initial multisim_client_start(SERVER_RUNTIME_DIRECTORY, server_name);

  // The polled word lands in a one-entry stage and moves into the FIFO on the
  // next edge; stage plus FIFO together behave as one FIFO_DEPTH-entry FWFT
  // queue with the stage as its newest slot, so it is popped directly only
  // when the FIFO behind it is empty.
  always_comb begin
    count      = f_count + CW'(stg_vld);
    data_vld   = (count != '0);
    pop        = data_vld && data_rdy;
    pop_stage  = pop && (f_count == '0);
    pop_fifo   = pop && (f_count != '0);
    push_fifo  = stg_vld && !pop_stage;
    fetch      = (count < CW'(FIFO_DEPTH)) && (backoff_cnt == '0);
    data       = '0;
    if (data_vld) data = (f_count != '0) ? f_head : stg_word;
    fill_level = count;
    poll_idle  = (backoff_cnt != '0);
  end

  // One server poll per enabled edge; an empty poll arms the backoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld     <= 1'b0;
      stg_word    <= '0;
      backoff_cnt <= '0;
    end else if (fetch) begin
      {stg_vld, stg_word, backoff_cnt} <= poll_server(server_name);
    end else begin
      stg_vld <= 1'b0;
      if (backoff_cnt != '0) backoff_cnt <= backoff_cnt - 1'b1;
    end
  end

  multisim_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_fifo),
    .wdata (stg_word),
    .pop   (pop_fifo),
    .count (f_count),
    .head  (f_head)
  );

endmodule
